// File: rtl/paddle_input_ctrl_if.sv
// paddle_input_ctrl_if: raw keys, frame pacing and step/level outputs of one player's paddle controller.
interface paddle_input_ctrl_if;
   logic key_up_n;
   logic key_down_n;
   logic frame_tick;
   logic enable;
   logic inc;
   logic dec;
   logic up_level;
   logic down_level;
   modport master (
      output key_up_n, key_down_n, frame_tick, enable,
      input  inc, dec, up_level, down_level
   );
   modport slave (
      input  key_up_n, key_down_n, frame_tick, enable,
      output inc, dec, up_level, down_level
   );
endinterface

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: debounced paddle keys to frame-paced inc/dec steps with hold-to-repeat.
// Define PADDLE_ACCEL_EN to drop the repeat interval to one frame after ACCEL_AFTER repeat steps.
module paddle_input_ctrl #(
   parameter int DB_CYCLES    = 500000,
   parameter int DB_WIDTH     = 19,
   parameter int REPEAT_DELAY = 12,
   parameter int REPEAT_RATE  = 2,
   parameter int FRAME_WIDTH  = 6,
   parameter int ACCEL_AFTER  = 16
) (
   input logic               clk,
   input logic               reset,
   paddle_input_ctrl_if.slave pad_io
);
   typedef enum logic [1:0] {IDLE, ARMED, DELAY, REPEAT} state_t;
   typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;
   localparam logic [DB_WIDTH-1:0]    DB_LAST   = DB_WIDTH'(DB_CYCLES - 1);
   localparam logic [FRAME_WIDTH-1:0] DLY_LAST  = FRAME_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [FRAME_WIDTH-1:0] RATE_LAST = FRAME_WIDTH'(REPEAT_RATE - 1);
   if ((64'd1 << DB_WIDTH) <= 64'(DB_CYCLES) || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || ACCEL_AFTER < 1)
   begin : g_bad_params
   end
   logic [1:0] raw_n;
   logic [1:0] lvl;
   assign raw_n = {pad_io.key_down_n, pad_io.key_up_n};
   for (genvar g = 0; g < 2; g++) begin : g_key
      logic                s1_q, s2_q, lvl_q, lvl_d;
      logic [DB_WIDTH-1:0] cnt_q, cnt_d;
      logic                differ, flip;
      always_comb begin
         differ = ~s2_q != lvl_q;
         flip   = differ && cnt_q == DB_LAST;
         cnt_d  = (!differ || flip) ? '0 : cnt_q + DB_WIDTH'(1);
         lvl_d  = lvl_q ^ flip;
      end
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            lvl_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            s1_q  <= raw_n[g];
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
         end
      assign lvl[g] = lvl_q;
   end
   state_t                 state_q;
   dir_t                   dir_q, dir_d;
   logic [FRAME_WIDTH-1:0] fcnt_q, fcnt_sat, rpt_last;
   logic                   inc_q, dec_q, abort, step;
`ifdef PADDLE_ACCEL_EN
   localparam int RW = $clog2(ACCEL_AFTER + 1);
   localparam logic [RW-1:0] ACC_LAST = RW'(ACCEL_AFTER);
   logic [RW-1:0] rcnt_q;
   assign rpt_last = (rcnt_q == ACC_LAST) ? '0 : RATE_LAST;
`else
   assign rpt_last = RATE_LAST;
`endif
   always_comb begin
      dir_d    = (lvl[0] & ~lvl[1]) ? UP : (lvl[1] & ~lvl[0]) ? DOWN : NONE;
      abort    = dir_d != dir_q || !pad_io.enable;
      fcnt_sat = (fcnt_q == '1) ? fcnt_q : fcnt_q + FRAME_WIDTH'(1);
      step     = state_q == ARMED || (state_q == DELAY && fcnt_q >= DLY_LAST)
              || (state_q == REPEAT && fcnt_q >= rpt_last);
   end
   // Abort is checked before frame_tick so a coincident tick never steps a stale direction.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= NONE;
         fcnt_q  <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
`ifdef PADDLE_ACCEL_EN
         rcnt_q  <= '0;
`endif
      end else begin
         inc_q <= 1'b0;
         dec_q <= 1'b0;
         if (state_q == IDLE) begin
            if (pad_io.enable && dir_d != NONE) begin
               dir_q   <= dir_d;
               fcnt_q  <= '0;
               state_q <= ARMED;
            end
         end else if (abort) begin
            state_q <= IDLE;
         end else if (pad_io.frame_tick) begin
            fcnt_q <= step ? '0 : fcnt_sat;
            inc_q  <= step && dir_q == DOWN;
            dec_q  <= step && dir_q == UP;
            if (state_q == ARMED) state_q <= DELAY;
            else if (state_q == DELAY && step) state_q <= REPEAT;
         end
`ifdef PADDLE_ACCEL_EN
         if (state_q != REPEAT || abort) rcnt_q <= '0;
         else if (pad_io.frame_tick && step && rcnt_q != ACC_LAST) rcnt_q <= rcnt_q + RW'(1);
`endif
      end
   assign pad_io.inc        = inc_q;
   assign pad_io.dec        = dec_q;
   assign pad_io.up_level   = lvl[0];
   assign pad_io.down_level = lvl[1];
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed checks of debounce, step pacing, abort and async reset.
module tb_paddle_input_ctrl;
   logic clk = 1'b0;
   logic reset;
   paddle_input_ctrl_if bus ();
   paddle_input_ctrl #(
      .DB_CYCLES(4), .DB_WIDTH(3), .REPEAT_DELAY(3), .REPEAT_RATE(2),
      .FRAME_WIDTH(4), .ACCEL_AFTER(2)
   ) dut (
      .clk(clk), .reset(reset), .pad_io(bus)
   );
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   int n = 0, inc_cnt = 0, dec_cnt = 0, both_cnt = 0, dl_hi = 0;
   int inc_q[$];
   int exp_q[$];
   int n0, t1, k;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask
   // Edge n is observed 1ns after it; frame_tick is sampled on edges that are multiples of 10.
   task automatic step_clk();
      @(posedge clk);
      #1;
      n++;
      if (bus.inc === 1'b1) begin inc_cnt++; inc_q.push_back(n); end
      if (bus.dec === 1'b1) dec_cnt++;
      if (bus.inc === 1'b1 && bus.dec === 1'b1) both_cnt++;
      if (bus.down_level === 1'b1) dl_hi++;
      bus.frame_tick = ((n + 1) % 10 == 0);
   endtask
   initial begin
      reset = 1'b1;
      bus.key_up_n = 1'b1;
      bus.key_down_n = 1'b1;
      bus.enable = 1'b1;
      bus.frame_tick = 1'b0;
      repeat (3) step_clk();
      chk("rst_inc", bus.inc, 0);
      chk("rst_dec", bus.dec, 0);
      chk("rst_up_level", bus.up_level, 0);
      chk("rst_down_level", bus.down_level, 0);
      reset = 1'b0;
      repeat (5) step_clk();
      inc_cnt = 0; dec_cnt = 0; dl_hi = 0;
      bus.key_down_n = 1'b0;
      repeat (3) step_clk();
      bus.key_down_n = 1'b1;
      repeat (12) step_clk();
      chk("bounce_level", dl_hi, 0);
      chk("bounce_inc", inc_cnt, 0);
      chk("bounce_dec", dec_cnt, 0);
      // Press so the level rises on edge 10k+9: ARMED is entered on a tick edge, which must be ignored.
      while (n % 10 != 3) step_clk();
      n0 = n;
      bus.key_down_n = 1'b0;
      inc_q.delete(); inc_cnt = 0; dec_cnt = 0; both_cnt = 0;
      k = 0;
      while (bus.down_level !== 1'b1 && k < 20) begin step_clk(); k++; end
      chk("db_latency", n - n0, 6);
      t1 = n0 + 17;
      repeat (101) step_clk();
`ifdef PADDLE_ACCEL_EN
      exp_q = '{0, 30, 50, 70, 80, 90};
`else
      exp_q = '{0, 30, 50, 70, 90};
`endif
      chk("hold_count", inc_q.size(), exp_q.size());
      foreach (exp_q[i])
         chk($sformatf("hold_step%0d", i), (inc_q.size() > i) ? inc_q[i] - t1 : -1, exp_q[i]);
      chk("hold_dec", dec_cnt, 0);
      chk("hold_both", both_cnt, 0);
      bus.key_up_n = 1'b0;
      k = 0;
      while (bus.up_level !== 1'b1 && k < 20) begin step_clk(); k++; end
      chk("up_rise", bus.up_level, 1);
      repeat (2) step_clk();
      inc_cnt = 0; dec_cnt = 0;
      repeat (30) step_clk();
      chk("both_keys_inc", inc_cnt, 0);
      chk("both_keys_dec", dec_cnt, 0);
      while (n % 10 != 3) step_clk();
      n0 = n;
      bus.key_up_n = 1'b1;
      inc_q.delete();
      repeat (50) step_clk();
      chk("rearm_count", inc_q.size(), 2);
      chk("rearm_first", (inc_q.size() > 0) ? inc_q[0] - n0 : -1, 17);
      chk("rearm_delay", (inc_q.size() > 1) ? inc_q[1] - n0 : -1, 47);
      // Level falls on edge n0+66; the REPEAT tick on n0+67 must be aborted.
      repeat (10) step_clk();
      bus.key_down_n = 1'b1;
      n0 = n; inc_cnt = 0;
      k = 0;
      while (bus.down_level !== 1'b0 && k < 20) begin step_clk(); k++; end
      chk("release_latency", n - n0, 6);
      repeat (30) step_clk();
      chk("release_inc", inc_cnt, 0);
      chk("release_dec", dec_cnt, 0);
      while (n % 10 != 3) step_clk();
      bus.key_down_n = 1'b0;
      inc_cnt = 0;
      k = 0;
      while (inc_cnt < 3 && k < 150) begin step_clk(); k++; end
      chk("pre_rst_inc", bus.inc, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_inc", bus.inc, 0);
      chk("async_rst_dec", bus.dec, 0);
      chk("async_rst_up", bus.up_level, 0);
      chk("async_rst_down", bus.down_level, 0);
      repeat (2) step_clk();
      reset = 1'b0;
      n0 = n;
      k = 0;
      while (bus.down_level !== 1'b1 && k < 20) begin step_clk(); k++; end
      chk("post_rst_latency", n - n0, 6);
      chk("total_both", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
